// File: rtl/implication_monitor_pkg.sv
// -----------------------------------------------------------------------------
// implication_monitor_pkg
// Shared definitions for the implication monitor:
//   - default parameter values (channel count, max delay, counter width)
//   - calc_dw(): width of a per-channel delay field for a given MAX_DLY
//   - chan_res_t: per-channel registered result (pass / fail pulse pair)
// -----------------------------------------------------------------------------
package implication_monitor_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_MAX_DLY = 7;
  localparam int DEF_CNT_W   = 16;

  // Delay field must hold 0..MAX_DLY inclusive.
  function automatic int calc_dw(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

  typedef struct packed {
    logic pass;
    logic fail;
  } chan_res_t;

endpackage

// File: rtl/implication_chan.sv
// -----------------------------------------------------------------------------
// implication_chan
// One implication channel: checks a |-> ##dly b.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : allows new obligations to be launched
//   i_clr          : synchronous clear of counters and sticky flag
//   i_a, i_b       : antecedent / consequent
//   i_dly          : antecedent-to-consequent delay (values above MAX_DLY clamp)
//   o_res          : registered one-cycle pass / fail pulses
//   o_err_sticky   : set on first fail, held until clear or reset
//   o_pass_cnt     : saturating pass count
//   o_fail_cnt     : saturating fail count
//
// Pending obligations live in an age-indexed bit vector: r_pend[j] means an
// obligation was launched j+1 edges before the upcoming edge. With a fixed
// delay d, the obligation in r_pend[d-1] is due at the upcoming edge. Since a
// delay change flushes the vector, every set bit always belongs to the current
// delay, so at most one obligation is due per edge and launch order is kept.
// MAX_DLY must be at least 1.
// -----------------------------------------------------------------------------
module implication_chan
  import implication_monitor_pkg::*;
#(
  parameter int MAX_DLY = DEF_MAX_DLY,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DW      = calc_dw(MAX_DLY)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_a,
  input  logic             i_b,
  input  logic [DW-1:0]    i_dly,
  output chan_res_t        o_res,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt
);

  logic [DW-1:0]      w_d;
  logic [DW-1:0]      r_dly_q;
  logic [MAX_DLY-1:0] r_pend;
  logic [MAX_DLY-1:0] w_pend_nxt;
  logic               w_chg;
  logic               w_launch;
  logic               w_imm;
  logic               w_due;
  logic               w_pass;
  logic               w_fail;

  // Clamp out-of-range delays to the deepest supported window.
  assign w_d = (i_dly > DW'(MAX_DLY)) ? DW'(MAX_DLY) : i_dly;

  // Any change of the raw delay value flushes everything still pending.
  assign w_chg    = (i_dly != r_dly_q);
  assign w_launch = i_en & i_a;
  // Zero delay: antecedent and consequent come from the same edge.
  assign w_imm    = w_launch & (w_d == '0);

  always_comb begin
    w_due = 1'b0;
    for (int j = 0; j < MAX_DLY; j++) begin
      if (int'(w_d) == j + 1) w_due = r_pend[j] & ~w_chg;
    end
  end

  // Age every pending obligation by one; drop those evaluated now (age
  // reaching d) and everything on a delay change. A fresh launch enters at
  // age 1 only when it is not evaluated immediately.
  always_comb begin
    w_pend_nxt    = '0;
    w_pend_nxt[0] = w_launch & (w_d != '0);
    for (int j = 1; j < MAX_DLY; j++) begin
      w_pend_nxt[j] = r_pend[j-1] & ~w_chg & (j < int'(w_d));
    end
  end

  assign w_pass = (w_due | w_imm) &  i_b;
  assign w_fail = (w_due | w_imm) & ~i_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dly_q      <= '0;
      r_pend       <= '0;
      o_res        <= '0;
      o_err_sticky <= 1'b0;
      o_pass_cnt   <= '0;
      o_fail_cnt   <= '0;
    end else begin
      r_dly_q     <= i_dly;
      r_pend      <= w_pend_nxt;
      o_res.pass  <= w_pass;
      o_res.fail  <= w_fail;
      // Clear beats a same-edge increment / set; pulses above still go out.
      if (i_clr) begin
        o_err_sticky <= 1'b0;
        o_pass_cnt   <= '0;
        o_fail_cnt   <= '0;
      end else begin
        if (w_fail) o_err_sticky <= 1'b1;
        if (w_pass && (o_pass_cnt != '1)) o_pass_cnt <= o_pass_cnt + 1'b1;
        if (w_fail && (o_fail_cnt != '1)) o_fail_cnt <= o_fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/implication_monitor.sv
// -----------------------------------------------------------------------------
// implication_monitor
// NUM_CH independent implication checkers (a[i] |-> ##dly[i] b[i]).
//   clk, rst   : clock, asynchronous active-high reset
//   en         : enables launch of new obligations (in-flight ones always finish)
//   clr        : synchronous clear of all counters and sticky flags
//   a, b       : per-channel antecedent / consequent
//   dly        : per-channel delay, 0 = overlapped
//   pass, fail : per-channel one-cycle result pulses
//   err_sticky : per-channel sticky fail flag
//   pass_cnt   : per-channel saturating pass count
//   fail_cnt   : per-channel saturating fail count
//   any_err    : OR of all sticky flags
// -----------------------------------------------------------------------------
module implication_monitor
  import implication_monitor_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int MAX_DLY = DEF_MAX_DLY,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int DW      = calc_dw(MAX_DLY)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [NUM_CH-1:0]            a,
  input  logic [NUM_CH-1:0]            b,
  input  logic [NUM_CH-1:0][DW-1:0]    dly,
  output logic [NUM_CH-1:0]            pass,
  output logic [NUM_CH-1:0]            fail,
  output logic [NUM_CH-1:0]            err_sticky,
  output logic [NUM_CH-1:0][CNT_W-1:0] pass_cnt,
  output logic [NUM_CH-1:0][CNT_W-1:0] fail_cnt,
  output logic                         any_err
);

  chan_res_t w_res [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    implication_chan #(
      .MAX_DLY (MAX_DLY),
      .CNT_W   (CNT_W),
      .DW      (DW)
    ) u_chan (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_clr        (clr),
      .i_a          (a[i]),
      .i_b          (b[i]),
      .i_dly        (dly[i]),
      .o_res        (w_res[i]),
      .o_err_sticky (err_sticky[i]),
      .o_pass_cnt   (pass_cnt[i]),
      .o_fail_cnt   (fail_cnt[i])
    );
    assign pass[i] = w_res[i].pass;
    assign fail[i] = w_res[i].fail;
  end

  assign any_err = |err_sticky;

endmodule

// File: tb/tb_implication_monitor.sv
module tb_implication_monitor;

  localparam int NCH = 4;
  localparam int MXD = 5;
  localparam int CW  = 3;
  localparam int DW  = 3;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    clr;
  logic [NCH-1:0]          a;
  logic [NCH-1:0]          b;
  logic [NCH-1:0][DW-1:0]  dly;
  logic [NCH-1:0]          pass;
  logic [NCH-1:0]          fail;
  logic [NCH-1:0]          err_sticky;
  logic [NCH-1:0][CW-1:0]  pass_cnt;
  logic [NCH-1:0][CW-1:0]  fail_cnt;
  logic                    any_err;

  implication_monitor #(
    .NUM_CH  (NCH),
    .MAX_DLY (MXD),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .a          (a),
    .b          (b),
    .dly        (dly),
    .pass       (pass),
    .fail       (fail),
    .err_sticky (err_sticky),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .any_err    (any_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {pass, fail} expected after each driven edge
  logic [2*NCH-1:0] exp_q[$];

  typedef struct packed {
    logic          en;
    logic          clr;
    logic          a;
    logic          b;
    logic [DW-1:0] d;
    logic          p;
    logic          f;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drive one edge, push its expected result, compare after the edge
  task automatic step(input logic s_en, input logic s_clr,
                      input logic [NCH-1:0] s_a, input logic [NCH-1:0] s_b,
                      input logic [NCH-1:0][DW-1:0] s_dly,
                      input logic [NCH-1:0] e_p, input logic [NCH-1:0] e_f,
                      input string name);
    logic [2*NCH-1:0] e;
    @(negedge clk);
    en  = s_en;
    clr = s_clr;
    a   = s_a;
    b   = s_b;
    dly = s_dly;
    exp_q.push_back({e_p, e_f});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'({pass, fail}), 32'(e));
    end
  endtask

  task automatic step0(input vec_t v, input string name);
    step(v.en, v.clr, {3'b0, v.a}, {3'b0, v.b}, {9'b0, v.d},
         {3'b0, v.p}, {3'b0, v.f}, name);
  endtask

  // reference model for the random phase
  int             due_q [NCH][$];
  logic [DW-1:0]  m_prev [NCH];
  logic [CW-1:0]  m_pc [NCH];
  logic [CW-1:0]  m_fc [NCH];
  logic [NCH-1:0] m_st;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    a   = '0;
    b   = '0;
    dly = '0;

    //                en clr a  b  d     p  f
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b1,3'd0,1'b1,1'b0}; // overlapped pass
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,3'd0,1'b0,1'b1}; // overlapped fail
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,3'd0,1'b0,1'b0}; // vacuous
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,3'd2,1'b0,1'b0}; // clr, dly -> 2
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0}; // launch A
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0}; // launch B
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,3'd2,1'b1,1'b0}; // A passes
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b1}; // B fails
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0}; // launch C
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0}; // en=0: no launch
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,3'd2,1'b1,1'b0}; // C still evaluated
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0}; // nothing from row 10
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0,3'd3,1'b0,1'b0}; // clr, dly -> 3
    tbl[14] = '{1'b1,1'b0,1'b1,1'b0,3'd3,1'b0,1'b0}; // launch D
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0}; // dly -> 1 discards D
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0}; // D would be due here
    tbl[18] = '{1'b1,1'b0,1'b1,1'b0,3'd7,1'b0,1'b0}; // dly 7 clamps to 5
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0};
    tbl[20] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0};
    tbl[21] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0};
    tbl[22] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0};
    tbl[23] = '{1'b1,1'b0,1'b0,1'b1,3'd7,1'b1,1'b0}; // 5 edges after row 18
    tbl[24] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0};
    tbl[25] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0}; // dly -> 1
    tbl[26] = '{1'b1,1'b0,1'b1,1'b1,3'd1,1'b0,1'b0}; // launch E
    tbl[27] = '{1'b1,1'b0,1'b1,1'b1,3'd1,1'b1,1'b0}; // E passes, launch F
    tbl[28] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b1}; // F fails
    tbl[29] = '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pass",   32'(pass), 32'd0);
    chk("rst_fail",   32'(fail), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_pcnt",   32'(pass_cnt), 32'd0);
    chk("rst_fcnt",   32'(fail_cnt), 32'd0);
    chk("rst_anyerr", 32'(any_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step0(tbl[i], $sformatf("vec%0d", i));
    chk("ovl_pcnt",   32'(pass_cnt), 32'd1);
    chk("ovl_fcnt",   32'(fail_cnt), 32'd1);
    chk("ovl_sticky", 32'(err_sticky), 32'd1);
    chk("ovl_anyerr", 32'(any_err), 32'd1);

    for (int i = 3; i < 13; i++) step0(tbl[i], $sformatf("vec%0d", i));
    chk("d2_pcnt", 32'(pass_cnt), 32'd2);
    chk("d2_fcnt", 32'(fail_cnt), 32'd1);

    for (int i = 13; i < 18; i++) step0(tbl[i], $sformatf("vec%0d", i));
    chk("chg_fcnt",   32'(fail_cnt), 32'd0);
    chk("chg_pcnt",   32'(pass_cnt), 32'd0);
    chk("chg_sticky", 32'(err_sticky), 32'd0);

    for (int i = 18; i < 30; i++) step0(tbl[i], $sformatf("vec%0d", i));
    chk("ovp_pcnt", 32'(pass_cnt), 32'd2);
    chk("ovp_fcnt", 32'(fail_cnt), 32'd1);

    // saturation, then clear racing a pass
    step(1'b1, 1'b1, 4'h0, 4'h0, '0, 4'h0, 4'h0, "sat_clr0");
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 4'h1, 4'h1, '0, 4'h1, 4'h0, $sformatf("sat%0d", i));
    chk("sat_pcnt", 32'(pass_cnt), 32'd7);
    step(1'b1, 1'b1, 4'h1, 4'h1, '0, 4'h1, 4'h0, "sat_clr_pulse");
    chk("sat_clr_pcnt", 32'(pass_cnt), 32'd0);
    chk("sat_clr_anyerr", 32'(any_err), 32'd0);

    // reset mid-window with dly=4 obligations in flight
    step(1'b1, 1'b0, 4'h1, 4'h0, '0, 4'h0, 4'h1, "pre_rst_fail");
    step(1'b1, 1'b0, 4'h1, 4'h1, {9'b0, 3'd4}, 4'h0, 4'h0, "pre_rst_l0");
    step(1'b1, 1'b0, 4'h1, 4'h1, {9'b0, 3'd4}, 4'h0, 4'h0, "pre_rst_l1");
    chk("pre_rst_fcnt", 32'(fail_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_fcnt",   32'(fail_cnt), 32'd0);
    chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
    chk("mid_rst_anyerr", 32'(any_err), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 4'h0, 4'hf, {9'b0, 3'd4}, 4'h0, 4'h0, $sformatf("post_rst%0d", i));

    // random phase against the reference model (all state empty after reset)
    for (int c = 0; c < NCH; c++) begin
      m_prev[c] = dly[c];
      m_pc[c]   = '0;
      m_fc[c]   = '0;
    end
    m_st = '0;
    for (int k = 0; k < 400; k++) begin
      logic                   r_en, r_clr;
      logic [NCH-1:0]         r_a, r_b, e_p, e_f;
      logic [NCH-1:0][DW-1:0] r_dly;
      r_en  = ($urandom_range(0, 7) != 0);
      r_clr = ($urandom_range(0, 31) == 0);
      r_a   = NCH'($urandom_range(0, 15));
      r_b   = NCH'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++)
        r_dly[c] = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 7)) : m_prev[c];
      e_p = '0;
      e_f = '0;
      for (int c = 0; c < NCH; c++) begin
        int de;
        de = (int'(r_dly[c]) > MXD) ? MXD : int'(r_dly[c]);
        if (r_dly[c] != m_prev[c]) due_q[c].delete();
        m_prev[c] = r_dly[c];
        if (due_q[c].size() > 0 && due_q[c][0] == k) begin
          void'(due_q[c].pop_front());
          if (r_b[c]) e_p[c] = 1'b1; else e_f[c] = 1'b1;
        end
        if (r_en && r_a[c]) begin
          if (de == 0) begin
            if (r_b[c]) e_p[c] = 1'b1; else e_f[c] = 1'b1;
          end else begin
            due_q[c].push_back(k + de);
          end
        end
        if (r_clr) begin
          m_pc[c] = '0;
          m_fc[c] = '0;
          m_st[c] = 1'b0;
        end else begin
          if (e_p[c] && m_pc[c] != 3'd7) m_pc[c] = m_pc[c] + 3'd1;
          if (e_f[c] && m_fc[c] != 3'd7) m_fc[c] = m_fc[c] + 3'd1;
          if (e_f[c]) m_st[c] = 1'b1;
        end
      end
      step(r_en, r_clr, r_a, r_b, r_dly, e_p, e_f, $sformatf("rnd%0d", k));
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("rnd%0d_pcnt%0d", k, c), 32'(pass_cnt[c]), 32'(m_pc[c]));
        chk($sformatf("rnd%0d_fcnt%0d", k, c), 32'(fail_cnt[c]), 32'(m_fc[c]));
      end
      chk($sformatf("rnd%0d_sticky", k), 32'(err_sticky), 32'(m_st));
      chk($sformatf("rnd%0d_anyerr", k), 32'(any_err), 32'(|m_st));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/implication_monitor.md
IMPLICATION_MONITOR -- requirements
Module: implication_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent implication channels.
REQ-002 SHALL have parameter MAX_DLY, default 7: maximum antecedent-to-consequent delay in cycles; DW = $clog2(MAX_DLY+1).
REQ-003 SHALL have parameter CNT_W, default 16: width of each pass/fail counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  input  1  sole clock; all sampling on posedge
- rst  input  1  asynchronous, active-high reset
- en  input  1  enables launch of new obligations
- clr  input  1  synchronous clear of counters and sticky flags
- a  input  NUM_CH  antecedent per channel
- b  input  NUM_CH  consequent per channel
- dly  input  NUM_CH x DW  per-channel delay; 0 = overlapped (a|->b), N = a|->##N b
- pass  output  NUM_CH  one-cycle pulse when an obligation is met
- fail  output  NUM_CH  one-cycle pulse when an obligation is violated
- err_sticky  output  NUM_CH  set on first fail, held until clr or rst
- pass_cnt  output  NUM_CH x CNT_W  saturating pass count
- fail_cnt  output  NUM_CH x CNT_W  saturating fail count
- any_err  output  1  OR of err_sticky

Function
REQ-005 SHALL launch an obligation on channel i at a posedge where en=1 and a[i]=1; a[i]=0 (vacuous) SHALL launch nothing and count nothing.
REQ-006 SHALL evaluate an obligation launched at edge k against b[i] sampled at edge k+dly[i].
REQ-007 SHALL register results: pass[i]/fail[i] assert for exactly one cycle after evaluation edge k+dly[i].
REQ-008 SHALL track up to MAX_DLY+1 overlapping obligations per channel (one per launch cycle); each evaluates independently, in launch order.
REQ-009 SHALL, with dly[i]=0, evaluate a[i] and b[i] from the same edge (overlapped semantics).
REQ-010 SHALL, with en=0, still evaluate in-flight obligations to completion.
REQ-011 SHALL, when dly[i] changes value between consecutive edges, discard all pending obligations of channel i with no pass/fail; launches at the change edge use the new value.
REQ-012 SHALL increment pass_cnt[i]/fail_cnt[i] by one per result, saturating at 2^CNT_W-1 (no wrap).
REQ-013 SHALL set err_sticky[i] on the edge fail[i] is registered.
REQ-014 SHALL on clr=1 zero all counters and err_sticky; clr wins over a same-edge increment/set, but pass/fail pulses are still emitted and pending obligations kept.
REQ-015 SHALL treat dly[i] > MAX_DLY as MAX_DLY.
REQ-016 SHALL keep channels fully independent; no cross-channel interaction except any_err.

Reset
REQ-017 SHALL on rst=1 asynchronously clear pass, fail, err_sticky, pass_cnt, fail_cnt, any_err to 0 and discard all pending obligations.
REQ-018 SHALL, after rst deasserts mid-operation, not report results for obligations launched before reset.

Structure
REQ-019 SHALL place default parameter values, DW derivation and the per-channel result typedef (pass, fail) in package implication_monitor_pkg.
REQ-020 SHALL instantiate NUM_CH copies of sub-module implication_chan (obligation shift register, evaluator, counters, sticky); the top only generates channels and ORs any_err.

Verification
REQ-021 dly=0, a=1 b=1 from t=12 -> pass pulse after next posedge (t=15), pass_cnt=1, no fail.
REQ-022 dly=0, a=1 b=0 at posedge t=25 -> fail after t=25, err_sticky=1, any_err=1; a=0 b=1 at t=35 -> no pulse, counts unchanged.
REQ-023 dly=2, a=1 at edge 3, b=1 at edge 5 only, a=1 at edge 4 -> pass after edge 5, fail after edge 6.
REQ-024 dly=3, a=1 at edge 2, dly->1 at edge 3 -> no result for edge-2 obligation; fail_cnt stays 0.
REQ-025 CNT_W=3, 9 consecutive passes -> pass_cnt=7; clr -> 0 next edge.
REQ-026 dly=4 obligations pending, rst pulse mid-window -> all outputs 0 immediately, no pulse after release.
